// File: rtl/pong_pkg.sv
// Shared types and constants for the pong scan renderer: 3x5 digit font
// and the frame-sequencer state encoding.
package pong_pkg;

    localparam int unsigned GLYPH_W    = 3;
    localparam int unsigned GLYPH_H    = 5;
    localparam int unsigned GLYPH_BITS = GLYPH_W * GLYPH_H;

    // Row-major glyphs, MSB is the top-left pixel.
    localparam logic [GLYPH_BITS-1:0] FONT_3X5 [0:9] = '{
        15'b111_101_101_101_111,
        15'b010_110_010_010_111,
        15'b111_001_111_100_111,
        15'b111_001_111_001_111,
        15'b101_101_111_001_001,
        15'b111_100_111_001_111,
        15'b111_100_111_101_111,
        15'b111_001_001_001_001,
        15'b111_101_111_101_111,
        15'b111_101_111_001_111
    };

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        BUILD,
        PRESENT,
        DONE
    } state_e;

    // Scores above 9 have no glyph and render blank.
    function automatic logic [GLYPH_BITS-1:0] glyph_of(input logic [3:0] digit);
        logic [GLYPH_BITS-1:0] g;
        g = '0;
        if (digit <= 4'd9) begin
            g = FONT_3X5[digit];
        end
        return g;
    endfunction

endpackage

// File: rtl/pong_scan_render_pixel.sv
// Combinational pixel evaluator: one (x, y) of the snapshotted scene to a
// single lit/unlit bit. Range checks run one bit wider so nothing wraps.
module pong_pixel_eval
    import pong_pkg::*;
#(
    parameter int unsigned COLS        = 64,
    parameter int unsigned ROWS        = 64,
    parameter int unsigned PADDLE_LEN  = 6,
    parameter int unsigned P1_X        = 0,
    parameter int unsigned P2_X        = 62,
    parameter int unsigned MID_X       = 30,
    parameter int unsigned DASH_PERIOD = 3,
    parameter int unsigned DASH_ON     = 2,
    parameter int unsigned SC1_X       = 14,
    parameter int unsigned SC2_X       = 46,
    parameter int unsigned SC_Y        = 1,
    localparam int unsigned XW = $clog2(COLS),
    localparam int unsigned YW = $clog2(ROWS)
)(
    input  logic [XW-1:0] x_i,
    input  logic [YW-1:0] y_i,
    input  logic [XW-1:0] bx_i,
    input  logic [YW-1:0] by_i,
    input  logic [YW-1:0] p1y_i,
    input  logic [YW-1:0] p2y_i,
    input  logic [3:0]    sc1_i,
    input  logic [3:0]    sc2_i,
    output logic          pixel_c_o
);

    logic [XW:0] xe;
    logic [YW:0] ye;
    logic        hit_p1, hit_p2, hit_ball, hit_mid, hit_sc1, hit_sc2;

    function automatic logic paddle_hit(input logic [XW:0] xv, input logic [YW:0] yv,
                                        input logic [YW-1:0] top, input int unsigned col);
        logic [YW:0] t;
        t = {1'b0, top};
        return ((xv == (XW+1)'(col)) || (xv == (XW+1)'(col + 1)))
            && (yv >= t) && (yv < t + (YW+1)'(PADDLE_LEN));
    endfunction

    function automatic logic digit_hit(input logic [XW:0] xv, input logic [YW:0] yv,
                                       input logic [3:0] score, input int unsigned ox);
        logic [XW:0]            gx;
        logic [YW:0]            gy;
        logic [GLYPH_BITS-1:0]  glyph;
        int unsigned            idx;
        logic                   in_box;
        gx     = xv - (XW+1)'(ox);
        gy     = yv - (YW+1)'(SC_Y);
        in_box = (xv >= (XW+1)'(ox)) && (gx < (XW+1)'(GLYPH_W))
              && (yv >= (YW+1)'(SC_Y)) && (gy < (YW+1)'(GLYPH_H));
        idx    = GLYPH_BITS - 1 - (GLYPH_W * 32'(gy) + 32'(gx));
        glyph  = glyph_of(score);
        return in_box && glyph[idx[3:0]];
    endfunction

    always_comb begin
        xe        = {1'b0, x_i};
        ye        = {1'b0, y_i};
        hit_p1    = paddle_hit(xe, ye, p1y_i, P1_X);
        hit_p2    = paddle_hit(xe, ye, p2y_i, P2_X);
        hit_ball  = (x_i == bx_i) && (y_i == by_i);
        hit_mid   = (xe == (XW+1)'(MID_X)) && ((32'(y_i) % DASH_PERIOD) < DASH_ON);
        hit_sc1   = digit_hit(xe, ye, sc1_i, SC1_X);
        hit_sc2   = digit_hit(xe, ye, sc2_i, SC2_X);
        pixel_c_o = hit_p1 | hit_p2 | hit_ball | hit_mid | hit_sc1 | hit_sc2;
    end

endmodule

// File: rtl/pong_scan_render.sv
// Frame sequencer for the pong LED matrix: snapshots the game state once per
// frame, builds each row one pixel per cycle and hands it off via valid/ready.
module pong_scan_render
    import pong_pkg::*;
#(
    parameter int unsigned COLS        = 64,
    parameter int unsigned ROWS        = 64,
    parameter int unsigned PADDLE_LEN  = 6,
    parameter int unsigned P1_X        = 0,
    parameter int unsigned P2_X        = 62,
    parameter int unsigned MID_X       = 30,
    parameter int unsigned DASH_PERIOD = 3,
    parameter int unsigned DASH_ON     = 2,
    parameter int unsigned SC1_X       = 14,
    parameter int unsigned SC2_X       = 46,
    parameter int unsigned SC_Y        = 1,
    localparam int unsigned XW = $clog2(COLS),
    localparam int unsigned YW = $clog2(ROWS)
)(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            enable,
    input  logic [XW-1:0]   bx,
    input  logic [YW-1:0]   by,
    input  logic [YW-1:0]   p1y,
    input  logic [YW-1:0]   p2y,
    input  logic [3:0]      sc1,
    input  logic [3:0]      sc2,
    output logic [COLS-1:0] row_data,
    output logic [YW-1:0]   row_addr,
    output logic            row_valid,
    input  logic            row_ready,
    output logic            frame_start,
    output logic            frame_done
);

    state_e          state_q;
    logic [XW-1:0]   x_q;
    logic [YW-1:0]   row_q;
    logic [COLS-2:0] shift_q;
    logic [COLS-1:0] data_q;
    logic            valid_q;
    logic            start_q;
    logic            done_q;

    logic [XW-1:0]   bx_q;
    logic [YW-1:0]   by_q;
    logic [YW-1:0]   p1y_q;
    logic [YW-1:0]   p2y_q;
    logic [3:0]      sc1_q;
    logic [3:0]      sc2_q;

    logic            pixel_c;
    logic [COLS-1:0] shift_d;
    logic            last_col_c;
    logic            last_row_c;

    pong_pixel_eval #(
        .COLS        (COLS),
        .ROWS        (ROWS),
        .PADDLE_LEN  (PADDLE_LEN),
        .P1_X        (P1_X),
        .P2_X        (P2_X),
        .MID_X       (MID_X),
        .DASH_PERIOD (DASH_PERIOD),
        .DASH_ON     (DASH_ON),
        .SC1_X       (SC1_X),
        .SC2_X       (SC2_X),
        .SC_Y        (SC_Y)
    ) u_pixel (
        .x_i       (x_q),
        .y_i       (row_q),
        .bx_i      (bx_q),
        .by_i      (by_q),
        .p1y_i     (p1y_q),
        .p2y_i     (p2y_q),
        .sc1_i     (sc1_q),
        .sc2_i     (sc2_q),
        .pixel_c_o (pixel_c)
    );

    // New pixel enters at the top, so after COLS cycles column 0 sits in bit 0.
    assign shift_d    = {pixel_c, shift_q};
    assign last_col_c = (x_q == XW'(COLS - 1));
    assign last_row_c = (row_q == YW'(ROWS - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            x_q     <= '0;
            row_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            start_q <= 1'b0;
            done_q  <= 1'b0;
            bx_q    <= '0;
            by_q    <= '0;
            p1y_q   <= '0;
            p2y_q   <= '0;
            sc1_q   <= '0;
            sc2_q   <= '0;
        end else begin
            start_q <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (enable) begin
                        start_q <= 1'b1;
                        state_q <= LATCH;
                    end
                end
                LATCH: begin
                    bx_q    <= bx;
                    by_q    <= by;
                    p1y_q   <= p1y;
                    p2y_q   <= p2y;
                    sc1_q   <= sc1;
                    sc2_q   <= sc2;
                    row_q   <= '0;
                    x_q     <= '0;
                    state_q <= BUILD;
                end
                BUILD: begin
                    shift_q <= shift_d[COLS-1:1];
                    if (last_col_c) begin
                        data_q  <= shift_d;
                        valid_q <= 1'b1;
                        x_q     <= '0;
                        state_q <= PRESENT;
                    end else begin
                        x_q <= x_q + XW'(1);
                    end
                end
                PRESENT: begin
                    if (row_ready) begin
                        valid_q <= 1'b0;
                        if (last_row_c) begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            row_q   <= row_q + YW'(1);
                            state_q <= BUILD;
                        end
                    end
                end
                DONE: begin
                    if (enable) begin
                        start_q <= 1'b1;
                        state_q <= LATCH;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign row_data    = data_q;
    assign row_addr    = row_q;
    assign row_valid   = valid_q;
    assign frame_start = start_q;
    assign frame_done  = done_q;

endmodule

// File: tb/tb_pong_scan_render.sv
// Self-checking bench for pong_scan_render at the default 64x64 geometry.
module tb_pong_scan_render;

    localparam logic [2:0] TB_FONT [10][5] = '{
        '{3'd7, 3'd5, 3'd5, 3'd5, 3'd7},
        '{3'd2, 3'd6, 3'd2, 3'd2, 3'd7},
        '{3'd7, 3'd1, 3'd7, 3'd4, 3'd7},
        '{3'd7, 3'd1, 3'd7, 3'd1, 3'd7},
        '{3'd5, 3'd5, 3'd7, 3'd1, 3'd1},
        '{3'd7, 3'd4, 3'd7, 3'd1, 3'd7},
        '{3'd7, 3'd4, 3'd7, 3'd5, 3'd7},
        '{3'd7, 3'd1, 3'd1, 3'd1, 3'd1},
        '{3'd7, 3'd5, 3'd7, 3'd5, 3'd7},
        '{3'd7, 3'd5, 3'd7, 3'd1, 3'd7}
    };

    logic        clk = 1'b0;
    logic        rst_n, enable, row_ready;
    logic [5:0]  bx, by, p1y, p2y;
    logic [3:0]  sc1, sc2;
    logic [63:0] row_data;
    logic [5:0]  row_addr;
    logic        row_valid, frame_start, frame_done;

    pong_scan_render dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .bx          (bx),
        .by          (by),
        .p1y         (p1y),
        .p2y         (p2y),
        .sc1         (sc1),
        .sc2         (sc2),
        .row_data    (row_data),
        .row_addr    (row_addr),
        .row_valid   (row_valid),
        .row_ready   (row_ready),
        .frame_start (frame_start),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct { logic [5:0] addr; logic [63:0] data; } row_t;
    typedef struct { int row; logic [63:0] exp; } vec_t;

    row_t        exp_q[$];
    row_t        exp_e;
    logic [63:0] got_rows [64];
    int          n_tests  = 0;
    int          n_fail   = 0;
    int          xfer_cnt = 0;
    logic        prev_stall = 1'b0;
    logic [63:0] prev_data;
    logic [5:0]  prev_addr;

    function automatic logic [63:0] bit64(input int i);
        return 64'(1) << i;
    endfunction

    function automatic bit glyph_px(input int s, input int gx, input int gy);
        logic [2:0] r;
        if (s > 9 || gx < 0 || gx > 2 || gy < 0 || gy > 4) return 1'b0;
        r = TB_FONT[s][gy];
        return r[2-gx];
    endfunction

    function automatic logic [63:0] ref_row(input int y, input int b_x, input int b_y,
                                            input int l_y, input int r_y, input int s1, input int s2);
        logic [63:0] r;
        bit p;
        r = '0;
        for (int x = 0; x < 64; x++) begin
            p = 1'b0;
            if ((x == 0  || x == 1)  && y >= l_y && y <= l_y + 5) p = 1'b1;
            if ((x == 62 || x == 63) && y >= r_y && y <= r_y + 5) p = 1'b1;
            if (x == b_x && y == b_y) p = 1'b1;
            if (x == 30 && (y % 3) < 2) p = 1'b1;
            if (glyph_px(s1, x - 14, y - 1)) p = 1'b1;
            if (glyph_px(s2, x - 46, y - 1)) p = 1'b1;
            r[x] = p;
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Scoreboard: expectations queued at frame_start, popped on each transfer.
    always @(negedge clk) begin
        if (rst_n) begin
            if (frame_start) begin
                for (int y = 0; y < 64; y++)
                    exp_q.push_back('{6'(y), ref_row(y, int'(bx), int'(by), int'(p1y),
                                                     int'(p2y), int'(sc1), int'(sc2))});
            end
            if (prev_stall) begin
                check("stall_valid", 64'(row_valid), 64'(1));
                check("stall_data", row_data, prev_data);
                check("stall_addr", 64'(row_addr), 64'(prev_addr));
            end
            if (row_valid && row_ready) begin
                xfer_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_row", 64'(row_addr), 64'(1) << 63);
                end else begin
                    exp_e = exp_q.pop_front();
                    check("row_addr", 64'(row_addr), 64'(exp_e.addr));
                    check($sformatf("row_data[%0d]", exp_e.addr), row_data, exp_e.data);
                end
                got_rows[row_addr] = row_data;
            end
            prev_stall = row_valid && !row_ready;
            prev_data  = row_data;
            prev_addr  = row_addr;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_row_addr(input int a, input string name);
        int n;
        n = 0;
        do begin step(1); n++; end while (row_addr != 6'(a) && n < 10000);
        check(name, 64'(row_addr), 64'(a));
    endtask

    task automatic wait_fd(input string name);
        int n;
        n = 0;
        do begin step(1); n++; end while (!frame_done && n < 10000);
        check(name, 64'(frame_done), 64'(1));
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        do begin step(1); n++; end while (!row_valid && n < 10000);
        check(name, 64'(row_valid), 64'(1));
    endtask

    initial begin
        vec_t vecs[$];
        logic bad;
        int   cnt;
        int   x0;

        rst_n = 1'b0; enable = 1'b0; row_ready = 1'b1;
        bx = 6'd20; by = 6'd20; p1y = 6'd10; p2y = 6'd58; sc1 = 4'd0; sc2 = 4'd7;

        vecs.push_back('{0,  bit64(30)});
        vecs.push_back('{1,  bit64(14) | bit64(15) | bit64(16) | bit64(30) | bit64(46) | bit64(47) | bit64(48)});
        vecs.push_back('{2,  bit64(14) | bit64(16) | bit64(48)});
        vecs.push_back('{3,  bit64(14) | bit64(16) | bit64(30) | bit64(48)});
        vecs.push_back('{4,  bit64(14) | bit64(16) | bit64(30) | bit64(48)});
        vecs.push_back('{5,  bit64(14) | bit64(15) | bit64(16) | bit64(48)});
        vecs.push_back('{6,  bit64(30)});
        vecs.push_back('{9,  bit64(30)});
        vecs.push_back('{10, bit64(0) | bit64(1) | bit64(30)});
        vecs.push_back('{15, bit64(0) | bit64(1) | bit64(30)});
        vecs.push_back('{16, bit64(30)});
        vecs.push_back('{20, bit64(20)});
        vecs.push_back('{57, bit64(30)});
        vecs.push_back('{58, bit64(30) | bit64(62) | bit64(63)});
        vecs.push_back('{62, bit64(62) | bit64(63)});
        vecs.push_back('{63, bit64(30) | bit64(62) | bit64(63)});

        // Reset and idle
        step(2);
        check("reset_data", row_data, '0);
        check("reset_ctrl", 64'({row_addr, row_valid, frame_start, frame_done}), '0);
        rst_n = 1'b1;
        bad = 1'b0;
        repeat (100) begin
            step(1);
            if (row_data != '0 || row_addr != '0 || row_valid || frame_start || frame_done) bad = 1'b1;
        end
        check("idle_quiet", 64'(bad), '0);

        // Start, first-row latency and frame period
        enable = 1'b1;
        step(1);
        check("frame_start_pulse", 64'(frame_start), 64'(1));
        cnt = 0;
        do begin step(1); cnt++; end while (!row_valid && cnt < 200);
        check("first_valid_latency", 64'(cnt), 64'(65));
        check("first_row_addr", 64'(row_addr), '0);
        do begin step(1); cnt++; end while (!frame_start && cnt < 6000);
        check("frame_period", 64'(cnt), 64'(4162));

        for (int i = 0; i < vecs.size(); i++)
            check($sformatf("scene_a_row%0d", vecs[i].row), got_rows[vecs[i].row], vecs[i].exp);

        // Backpressure on row 5
        wait_row_addr(5, "bp_reach_row5");
        row_ready = 1'b0;
        wait_valid("bp_row5_valid");
        check("bp_hold_addr", 64'(row_addr), 64'(5));
        x0 = xfer_cnt;
        step(50);
        check("bp_no_transfer", 64'(xfer_cnt - x0), '0);
        check("bp_still_valid", 64'(row_valid), 64'(1));
        row_ready = 1'b1;
        step(1);
        check("bp_single_transfer", 64'(xfer_cnt - x0), 64'(1));

        // Mid-frame input change must wait for the next snapshot
        wait_row_addr(10, "snap_reach_row10");
        bx = 6'd40;
        wait_fd("snap_old_frame_done");
        check("snap_old_ball", got_rows[20], bit64(20));

        wait_row_addr(50, "snap_reach_row50");
        sc1 = 4'd12;
        p1y = 6'd63;
        wait_fd("snap_new_frame_done");
        check("snap_new_ball", got_rows[20], bit64(40));

        // Blank score, bottom-clipped paddle, enable drop mid-frame
        wait_row_addr(30, "en_reach_row30");
        enable = 1'b0;
        wait_fd("en_drop_frame_done");
        check("blank_score_row1", got_rows[1], bit64(30) | bit64(46) | bit64(47) | bit64(48));
        check("clip_paddle_row63", got_rows[63], bit64(0) | bit64(1) | bit64(30) | bit64(62) | bit64(63));
        check("clip_paddle_row0", got_rows[0], bit64(30));
        bad = 1'b0;
        repeat (30) begin
            step(1);
            if (frame_start || row_valid || frame_done) bad = 1'b1;
        end
        check("idle_after_drop", 64'(bad), '0);

        // Reset in the middle of a frame
        enable = 1'b1;
        wait_row_addr(40, "rst_reach_row40");
        rst_n = 1'b0;
        step(1);
        check("rst_mid_data", row_data, '0);
        check("rst_mid_ctrl", 64'({row_addr, row_valid, frame_start, frame_done}), '0);
        step(1);
        check("rst_mid_no_done", 64'(frame_done), '0);
        exp_q.delete();
        rst_n = 1'b1;
        step(1);
        check("restart_frame_start", 64'(frame_start), 64'(1));
        wait_valid("restart_valid");
        check("restart_row_addr", 64'(row_addr), '0);
        enable = 1'b0;
        wait_fd("restart_frame_done");
        step(3);
        check("scoreboard_drained", 64'(exp_q.size()), '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
